// File: rtl/mux5_rr_arbiter.sv
// Round-robin grant sequencer for the five-input data mux: holds a requester
// for a whole packet (or MAXBURST beats) and drives the downstream valid/ready handshake.
module mux5_rr_arbiter #(
   parameter int unsigned MAXBURST  = 8,
   parameter int unsigned WIREWIDTH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] req_i,
   input  logic [4:0] last_i,
   input  logic       out_ready_i,
   output logic [2:0] s_o,
   output logic [4:0] grant_o,
   output logic       out_valid_o,
   output logic       out_last_o,
   output logic [4:0] ready_o
);

   // Data width of the companion mux; the control path never looks at it.
   localparam int unsigned unused_data_w = WIREWIDTH + 1;
   localparam logic [7:0]  CNT_LIM = (MAXBURST == 0) ? 8'd0 : 8'(MAXBURST - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e     state_q, state_d;
   logic [2:0] s_q, s_d;
   logic [4:0] grant_q, grant_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;

   function automatic logic [2:0] inc5(input logic [2:0] x);
      return (x == 3'd4) ? 3'd0 : x + 3'd1;
   endfunction

   // Returns {hit, index} of the first set bit scanning start, start+1, ... mod 5.
   function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] start);
      logic       hit;
      logic [2:0] idx;
      logic [2:0] j;
      hit = 1'b0;
      idx = 3'd0;
      j   = start;
      for (int k = 0; k < 5; k++) begin
         if (!hit && r[j]) begin
            hit = 1'b1;
            idx = j;
         end
         j = inc5(j);
      end
      return {hit, idx};
   endfunction

   logic       busy, beat, eog;
   logic [3:0] idle_pick, busy_pick;

   assign busy        = (state_q == BUSY);
   assign out_valid_o = busy & |(req_i & grant_q);
   assign out_last_o  = out_valid_o & |(last_i & grant_q);
   assign ready_o     = grant_q & {5{out_ready_i}};
   assign s_o         = s_q;
   assign grant_o     = grant_q;

   assign beat = busy & out_valid_o & out_ready_i;
   assign eog  = beat & (out_last_o | ((MAXBURST != 0) && (cnt_q == CNT_LIM)));

   // The current owner is masked out so a rotation never re-grants it directly.
   assign idle_pick = rr_pick(req_i, inc5(ptr_q));
   assign busy_pick = rr_pick(req_i & ~grant_q, inc5(s_q));

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (idle_pick[3]) begin
               state_d = BUSY;
               s_d     = idle_pick[2:0];
               grant_d = 5'b00001 << idle_pick[2:0];
               ptr_d   = idle_pick[2:0];
               cnt_d   = 8'd0;
            end
         end
         BUSY: begin
            if (beat) cnt_d = cnt_q + 8'd1;
            if (eog) begin
               cnt_d = 8'd0;
               if (busy_pick[3]) begin
                  s_d     = busy_pick[2:0];
                  grant_d = 5'b00001 << busy_pick[2:0];
                  ptr_d   = busy_pick[2:0];
               end else begin
                  state_d = IDLE;
                  grant_d = 5'd0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= 3'd0;
         grant_q <= 5'd0;
         ptr_q   <= 3'd4;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench for mux5_rr_arbiter; u8 uses MAXBURST=8, u2 uses MAXBURST=2 on shared stimulus.
module tb_mux5_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] req = 5'd0, last = 5'd0;
   logic       ordy = 1'b1;

   logic [2:0] s8, s2;
   logic [4:0] g8, g2, rdy8, rdy2;
   logic       v8, v2, l8, l2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux5_rr_arbiter #(.MAXBURST(8), .WIREWIDTH(1)) u8 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .out_ready_i(ordy),
      .s_o(s8), .grant_o(g8), .out_valid_o(v8), .out_last_o(l8), .ready_o(rdy8));

   mux5_rr_arbiter #(.MAXBURST(2), .WIREWIDTH(1)) u2 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .last_i(last), .out_ready_i(ordy),
      .s_o(s2), .grant_o(g2), .out_valid_o(v2), .out_last_o(l2), .ready_o(rdy2));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset with the given inputs, releases it just after a rising edge.
   task automatic restart(input logic [4:0] r, input logic [4:0] l);
      rst_n = 1'b0;
      req   = r;
      last  = l;
      ordy  = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int sent[2];
      logic [2:0] bexp[10];

      // Reset with every requester active
      rst_n = 1'b0; req = 5'b11111; last = 5'd0; ordy = 1'b1;
      tick(); tick();
      chk("rst_grant", 8'(g8), 8'h00);
      chk("rst_s", 8'(s8), 8'h00);
      chk("rst_valid", 8'(v8), 8'h00);
      chk("rst_last", 8'(l8), 8'h00);
      chk("rst_ready", 8'(rdy8), 8'h00);
      rst_n = 1'b1;
      tick();
      chk("rel_s", 8'(s8), 8'h00);
      chk("rel_grant", 8'(g8), 8'h01);
      chk("rel_valid", 8'(v8), 8'h01);

      // Round robin with single-beat packets
      restart(5'b10101, 5'b11111);
      tick();
      for (int i = 0; i < 6; i++) begin
         logic [2:0] e;
         e = (i % 3 == 0) ? 3'd0 : (i % 3 == 1) ? 3'd2 : 3'd4;
         chk("rr_s", 8'(s8), 8'(e));
         chk("rr_grant", 8'(g8), 8'(5'b00001 << e));
         chk("rr_valid", 8'(v8), 8'h01);
         chk("rr_last", 8'(l8), 8'h01);
         tick();
      end

      // Packet hold: requester 3 sends 4 beats while requester 1 waits
      restart(5'b01000, 5'd0);
      tick();
      req = 5'b01010;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) last = 5'b01000;
         #1;
         chk("hold_s", 8'(s8), 8'h03);
         chk("hold_valid", 8'(v8), 8'h01);
         chk("hold_olast", 8'(l8), (i == 3) ? 8'h01 : 8'h00);
         tick();
      end
      chk("hold_next_s", 8'(s8), 8'h01);
      chk("hold_next_grant", 8'(g8), 8'h02);

      // Burst limit on u2: two 5-beat packets sliced into 2-beat grants
      bexp = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd1};
      restart(5'b00011, 5'd0);
      sent[0] = 0; sent[1] = 0;
      tick();
      for (int i = 0; i < 10; i++) begin
         last = {3'd0, sent[1] == 4, sent[0] == 4};
         #1;
         chk("burst_s", 8'(s2), 8'(bexp[i]));
         chk("burst_valid", 8'(v2), 8'h01);
         tick();
         sent[bexp[i]]++;
         if (sent[0] == 5) req[0] = 1'b0;
         if (sent[1] == 5) req[1] = 1'b0;
      end
      last = 5'd0;
      #1;
      chk("burst_idle_grant", 8'(g2), 8'h00);
      chk("burst_idle_s", 8'(s2), 8'h01);
      chk("burst_idle_valid", 8'(v2), 8'h00);

      // Stall and request drop must not advance the beat counter
      restart(5'b00011, 5'd0);
      tick();
      tick(); tick();
      ordy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", 8'(rdy8), 8'h00);
         tick();
         chk("stall_s", 8'(s8), 8'h00);
         chk("stall_grant", 8'(g8), 8'h01);
      end
      ordy = 1'b1;
      req  = 5'b00010;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("drop_valid", 8'(v8), 8'h00);
         tick();
         chk("drop_grant", 8'(g8), 8'h01);
      end
      req = 5'b00011;
      for (int i = 0; i < 5; i++) tick();
      chk("stall_cnt_s", 8'(s8), 8'h00);
      tick();
      chk("stall_rot_s", 8'(s8), 8'h01);

      // Idle return, then reset mid-packet
      restart(5'b00100, 5'd0);
      tick();
      chk("idle_s2", 8'(s8), 8'h02);
      tick();
      last = 5'b00100;
      tick();
      chk("idle_grant", 8'(g8), 8'h00);
      chk("idle_s", 8'(s8), 8'h02);
      chk("idle_valid", 8'(v8), 8'h00);
      req = 5'd0; last = 5'd0;
      tick();
      chk("idle_hold_s", 8'(s8), 8'h02);
      req = 5'b10000;
      tick();
      chk("r4_s", 8'(s8), 8'h04);
      chk("r4_grant", 8'(g8), 8'h10);
      tick();
      req = 5'b10011;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_grant", 8'(g8), 8'h00);
      chk("mid_rst_s", 8'(s8), 8'h00);
      chk("mid_rst_valid", 8'(v8), 8'h00);
      chk("mid_rst_ready", 8'(rdy8), 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_s", 8'(s8), 8'h00);
      chk("post_rst_grant", 8'(g8), 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux5_rr_arbiter.md
# mux5_rr_arbiter

Round-robin arbiter and sequencer for the five-input data mux. It shares one output channel between five requesters by driving the mux select `s` and a one-hot grant. It keeps a grant for a whole packet, up to a configurable beat limit, and provides a valid/ready handshake toward the downstream consumer. Data never passes through this block: the consumer samples the mux output `o` while `out_valid && out_ready`.

## Interface
- `MAXBURST`, default 8: maximum beats per grant before forced rotation. Range 1..255; 0 = unlimited.
- `WIREWIDTH`, default 1: width of the companion mux data path (WIREWIDTH+1 bits). Documentation only; unused by the control logic.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  5  per-requester request; bit i means d_i holds a valid beat.
- `last`  in  5  per-requester end-of-packet flag, qualified by `req[i]`.
- `out_ready`  in  1  downstream accepts a beat this cycle.
- `s`  out  3  mux select, registered; only values 0..4.
- `grant`  out  5  one-hot grant, registered; all zero when idle.
- `out_valid`  out  1  comb: `req[s]` while BUSY.
- `out_last`  out  1  comb: `out_valid & last[s]`.
- `ready`  out  5  comb: `grant & {5{out_ready}}`; a beat from requester i is consumed when `req[i] & ready[i]`.

## Operation
- Two states: IDLE and BUSY. Registers: `s`, `grant`, a 3-bit priority pointer `ptr` (last granted index), and an 8-bit beat counter `cnt`.
- Reset values: state IDLE, `s`=0, `grant`=0, `ptr`=4 (so the first search starts at index 0), `cnt`=0. Resulting outputs: `out_valid`=0, `out_last`=0, `ready`=0.
- Beat (`beat`) = BUSY & `out_valid` & `out_ready`.
- **IDLE:**
  - If `req`≠0, choose the winner: the first set bit searching ptr+1, ptr+2, … modulo 5.
  - Next edge: state←BUSY, `s`←winner, `grant`←onehot(winner), `ptr`←winner, `cnt`←0.
  - If `req`=0, hold all registers; `s` keeps its old value.
- **BUSY:**
  - On each beat, `cnt`←`cnt`+1.
  - End of grant = beat & (`last[s]` | (MAXBURST≠0 & `cnt`==MAXBURST−1)).
  - On end of grant, search the other four requesters, starting at s+1 modulo 5 and excluding s.
  - If one is found: grant it on the same edge (back-to-back, no dead cycle); update `s`, `grant` and `ptr`; set `cnt`←0.
  - If none is found: state←IDLE, `grant`←0, `cnt`←0, `s` unchanged.
- Requester drops `req[s]` mid-packet without `last`: grant is held, `out_valid`=0, no rotation. Requesters must keep `req` asserted until their last beat.
- Forced rotation at MAXBURST splits a packet. The requester re-arbitrates later and continues its packet on its next grant.
- `out_ready` low: no beat, no counter change, grant held indefinitely.
- `req`/`last` changes on non-granted bits have no effect while BUSY, except at end of grant.
- Reset asserted mid-packet: registers are cleared immediately (asynchronously). The in-flight packet is abandoned and arbitration restarts from index 0.

## Timing
- Request to first grant from IDLE: 1 cycle (req sampled at edge N, `grant`/`s` valid after edge N).
- Handshake outputs are combinational from `req`, `last` and `out_ready` given the registered `s`/`grant`; there is no combinational path from `out_ready` to `s`.
- Back-to-back handoff: the first beat of the next requester is possible in the cycle after the ending beat.
- Return to IDLE after the final packet: one dead cycle minimum before any new grant.
- Throughput: 1 beat/cycle while `out_ready`=1 and `req[s]`=1.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=5'b11111 -> `grant`=0, `s`=0, `out_valid`=0. Release -> one cycle later `s`=0, `grant`=5'b00001.
- **Round robin:** `req`=5'b10101, every requester sends 1-beat packets (`last`=1), `out_ready`=1 -> grant order 0,2,4,0,2,…, one beat per cycle, no dead cycles.
- **Packet hold:** requester 3 sends 4 beats with `last` on beat 4 while `req[1]` is high; MAXBURST=8 -> `s`=3 for 4 beats, then `s`=1 on the next cycle.
- **Burst limit:** MAXBURST=2; requesters 0 and 1 each send 5-beat packets -> grants alternate 0,1,0,1,0,1 in 2-beat slices.
- **Stall:** `out_ready` low for 3 cycles mid-packet -> `cnt`, `s` and `grant` unchanged, no beats. Hold `out_ready`=1 and drop `req[s]` for 2 cycles -> `out_valid`=0 and grant held.
- **Idle and reset mid-packet:** single requester 2 finishes its packet -> IDLE, `grant`=0, `s` stays 2. Assert `rst_n` low during a later packet from requester 4 -> outputs cleared at once; after release, the first winner is the lowest set `req` bit starting at index 0.
